// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch unit with predecode of B and a decoupling instruction queue
module ifetch_queue #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int IMM_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_req,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]           imem_rdata,
  input  logic                         exe_redirect,
  input  logic [ADDR_W-1:0]            exe_pc,
  input  logic [IMM_W-1:0]             exe_imm,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [INSTR_W-1:0]           instr_data,
  output logic [ADDR_W-1:0]            instr_pc,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0] OP_B = 7'b1100000;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0]  fetch_pc;
  logic               inflight;
  logic               resp_drop;
  logic [ADDR_W-1:0]  resp_pc;

  logic [INSTR_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0]  q_pc   [DEPTH];
  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic [CW-1:0]      count;

  logic               resp_live;
  logic               resp_is_b;
  logic               push;
  logic               pop;
  logic               credit_ok;
  logic [CW:0]        occupancy;
  logic [ADDR_W-1:0]  exe_target;
  logic [ADDR_W-1:0]  b_target;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A returning response is live unless it was tagged for drop or EXE is redirecting now
  assign resp_live  = inflight && !resp_drop && !exe_redirect;
  assign resp_is_b  = resp_live && (imem_rdata[31:25] == OP_B);
  assign push       = resp_live && !resp_is_b;
  assign pop        = instr_valid && instr_ready;

  assign exe_target = exe_pc + {{(ADDR_W-IMM_W){exe_imm[IMM_W-1]}}, exe_imm};
  assign b_target   = resp_pc + {{(ADDR_W-16){imem_rdata[15]}}, imem_rdata[15:0]};

  // Outstanding response counts against queue space so a push never finds the queue full
  assign occupancy  = {1'b0, count} + (CW+1)'(inflight);
  assign credit_ok  = occupancy < (CW+1)'(DEPTH);

  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != '0) && !exe_redirect;
  assign instr_data  = q_data[head];
  assign instr_pc    = q_pc[head];
  assign queue_count = count;

  // State register: IDLE for the first cycle out of reset, then RUN
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state: RUN is held until reset
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = S_RUN;
      S_RUN:   state_nx = S_RUN;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output decode: fetch only while running, with credit, and not during a redirect
  always_comb begin
    imem_req = 1'b0;
    if (state == S_RUN && credit_ok && !exe_redirect) imem_req = 1'b1;
  end

  // Fetch PC and in-flight response tag; EXE redirect beats a predecoded B
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      inflight  <= 1'b0;
      resp_drop <= 1'b0;
      resp_pc   <= RESET_PC;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        resp_pc   <= fetch_pc;
        resp_drop <= resp_is_b;
      end
      if (exe_redirect)  fetch_pc <= exe_target;
      else if (resp_is_b) fetch_pc <= b_target;
      else if (imem_req)  fetch_pc <= fetch_pc + ADDR_W'(4);
    end
  end

  // Instruction queue: circular buffer, flushed on redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (exe_redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q_data[tail] <= imem_rdata;
        q_pc[tail]   <= resp_pc;
        tail         <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - self-checking bench for ifetch_queue
module tb_ifetch_queue;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;
  localparam int IMM_W   = 16;
  localparam int CW      = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               exe_redirect = 1'b0;
  logic [ADDR_W-1:0]  exe_pc = '0;
  logic [IMM_W-1:0]   exe_imm = '0;
  logic               instr_valid;
  logic               instr_ready = 1'b0;
  logic [INSTR_W-1:0] instr_data;
  logic [ADDR_W-1:0]  instr_pc;
  logic [CW-1:0]      queue_count;

  int checks = 0;
  int failures = 0;

  ifetch_queue #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .IMM_W(IMM_W), .RESET_PC('0)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .exe_redirect(exe_redirect), .exe_pc(exe_pc), .exe_imm(exe_imm),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Program image: explicit B slots, optional hashed B pattern, otherwise ALU words tagged with the address
  logic        b_en_a = 1'b0, b_en_b = 1'b0, hash_b = 1'b0;
  logic [31:0] b_addr_a = '0, b_addr_b = '0;
  logic [15:0] b_imm_a = '0, b_imm_b = '0;

  function automatic logic [31:0] mk_b(input logic [15:0] imm);
    return {7'b1100000, 9'd0, imm};
  endfunction

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    if (b_en_a && a == b_addr_a) return mk_b(b_imm_a);
    if (b_en_b && a == b_addr_b) return mk_b(b_imm_b);
    if (hash_b && a[4:2] == 3'd5) return mk_b(a[5] ? 16'hFFE8 : 16'h0010);
    return {7'b0000001, a[24:0]};
  endfunction

  // Synchronous memory: answers the previous cycle's request, otherwise drives a B-looking garbage word
  logic        pend_req = 1'b0;
  logic [31:0] pend_addr = '0;
  always @(negedge clk) begin
    pend_req  = imem_req;
    pend_addr = imem_addr;
  end
  always @(posedge clk) begin
    #1;
    imem_rdata = pend_req ? instr_at(pend_addr) : 32'hC000_0040;
  end

  // Reference: the architectural instruction stream, restarted at each redirect target
  logic [31:0] gpc = '0;
  logic [31:0] sb_w;
  int          sb_guard;
  int          pops = 0;
  logic [31:0] popped_pc[$];
  always @(negedge clk) begin
    if (rst) begin
      gpc = '0;
    end else begin
      chk("valid_rule", instr_valid, (queue_count != 0) && !exe_redirect);
      chk("count_bound", queue_count <= DEPTH, 1'b1);
      if (instr_valid && instr_ready) begin
        sb_w = instr_at(gpc);
        sb_guard = 0;
        while (sb_w[31:25] == 7'b1100000 && sb_guard < 16) begin
          gpc = gpc + {{16{sb_w[15]}}, sb_w[15:0]};
          sb_w = instr_at(gpc);
          sb_guard++;
        end
        chk("pop_pc", instr_pc, gpc);
        chk("pop_data", instr_data, sb_w);
        popped_pc.push_back(instr_pc);
        pops++;
        gpc = gpc + 32'd4;
      end
      if (exe_redirect) gpc = exe_pc + {{16{exe_imm[15]}}, exe_imm};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_reset();
    rst = 1'b1;
    exe_redirect = 1'b0;
    step();
    step();
  endtask

  typedef struct {
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    int          e_count;
  } vec_t;
  vec_t tbl[$];

  task automatic add_row(input logic r, input logic q, input logic [31:0] a,
                         input logic v, input logic [31:0] p, input int c);
    tbl.push_back('{r, q, a, v, p, c});
  endtask

  logic [31:0] req_log[$];
  logic [31:0] exp_list[$];
  int          hits;
  int          pops_r;

  initial begin
    // Reset state
    step();
    @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_data", instr_data, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_count", queue_count, 0);

    // Reset release, streaming, then backpressure fill and drain
    add_row(1, 0, 32'h00, 0, 32'h00, 0);
    add_row(1, 1, 32'h00, 0, 32'h00, 0);
    add_row(1, 1, 32'h04, 0, 32'h00, 0);
    add_row(1, 1, 32'h08, 1, 32'h00, 1);
    add_row(1, 1, 32'h0C, 1, 32'h04, 1);
    add_row(1, 1, 32'h10, 1, 32'h08, 1);
    add_row(0, 1, 32'h14, 1, 32'h0C, 1);
    add_row(0, 1, 32'h18, 1, 32'h0C, 2);
    add_row(0, 0, 32'h1C, 1, 32'h0C, 3);
    for (int i = 0; i < 7; i++) add_row(0, 0, 32'h1C, 1, 32'h0C, 4);
    add_row(1, 0, 32'h1C, 1, 32'h0C, 4);
    add_row(1, 1, 32'h1C, 1, 32'h10, 3);
    add_row(1, 1, 32'h20, 1, 32'h14, 2);
    add_row(1, 1, 32'h24, 1, 32'h18, 2);
    add_row(1, 1, 32'h28, 1, 32'h1C, 2);
    add_row(1, 1, 32'h2C, 1, 32'h20, 2);
    step();
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      instr_ready = tbl[i].ready;
      @(negedge clk);
      chk($sformatf("t1_req_c%0d", i), imem_req, tbl[i].e_req);
      if (tbl[i].e_req || i == 0) chk($sformatf("t1_addr_c%0d", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("t1_valid_c%0d", i), instr_valid, tbl[i].e_valid);
      chk($sformatf("t1_count_c%0d", i), queue_count, tbl[i].e_count);
      if (tbl[i].e_valid) begin
        chk($sformatf("t1_pc_c%0d", i), instr_pc, tbl[i].e_pc);
        chk($sformatf("t1_data_c%0d", i), instr_data, instr_at(tbl[i].e_pc));
      end
      step();
    end

    // Predecoded B forward and backward
    start_reset();
    b_en_a = 1'b1; b_addr_a = 32'h08; b_imm_a = 16'h0010;
    b_en_b = 1'b1; b_addr_b = 32'h20; b_imm_b = 16'hFFF8;
    instr_ready = 1'b1;
    rst = 1'b0;
    popped_pc.delete();
    req_log.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req) req_log.push_back(imem_addr);
      step();
    end
    exp_list = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h18, 32'h1C};
    chk("t3_req_n", req_log.size() >= 10, 1'b1);
    for (int i = 0; i < 10 && i < req_log.size(); i++) chk($sformatf("t3_req%0d", i), req_log[i], exp_list[i]);
    exp_list = '{32'h0, 32'h4, 32'h18, 32'h1C, 32'h18, 32'h1C};
    chk("t3_pop_n", popped_pc.size() >= 6, 1'b1);
    for (int i = 0; i < 6 && i < popped_pc.size(); i++) chk($sformatf("t3_pop%0d", i), popped_pc[i], exp_list[i]);

    // EXE redirect with three entries queued
    start_reset();
    b_en_a = 1'b0; b_en_b = 1'b0;
    instr_ready = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    exe_redirect = 1'b1; exe_pc = 32'h40; exe_imm = 16'hFFF0;
    @(negedge clk);
    chk("t4_count_before", queue_count, 3);
    chk("t4_valid_redir", instr_valid, 1'b0);
    chk("t4_req_redir", imem_req, 1'b0);
    step();
    exe_redirect = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("t4_count_after", queue_count, 0);
    chk("t4_req_t1", imem_req, 1'b1);
    chk("t4_addr_t1", imem_addr, 32'h30);
    step();
    @(negedge clk);
    chk("t4_valid_t2", instr_valid, 1'b0);
    chk("t4_addr_t2", imem_addr, 32'h34);
    step();
    @(negedge clk);
    chk("t4_valid_t3", instr_valid, 1'b1);
    chk("t4_pc_t3", instr_pc, 32'h30);
    step();

    // EXE redirect coinciding with a B response: EXE target wins
    start_reset();
    b_en_a = 1'b1; b_addr_a = 32'h08; b_imm_a = 16'h00F8;
    instr_ready = 1'b1;
    rst = 1'b0;
    popped_pc.delete();
    for (int i = 0; i < 4; i++) step();
    exe_redirect = 1'b1; exe_pc = 32'h60; exe_imm = 16'h0020;
    @(negedge clk);
    chk("t5_valid_redir", instr_valid, 1'b0);
    step();
    exe_redirect = 1'b0;
    @(negedge clk);
    chk("t5_addr_t1", imem_addr, 32'h80);
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 32'h100) hits++;
      step();
    end
    chk("t5_no_b_target", hits, 0);
    exp_list = '{32'h0, 32'h80, 32'h84, 32'h88};
    chk("t5_pop_n", popped_pc.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < popped_pc.size(); i++) chk($sformatf("t5_pop%0d", i), popped_pc[i], exp_list[i]);

    // Reset mid-operation with queue occupied and a response in flight
    start_reset();
    b_en_a = 1'b0;
    instr_ready = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("t6_req", imem_req, 1'b0);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_valid", instr_valid, 1'b0);
    chk("t6_data", instr_data, 32'h0);
    chk("t6_pc", instr_pc, 32'h0);
    chk("t6_count", queue_count, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_idle_count", queue_count, 0);
    chk("t6_idle_req", imem_req, 1'b0);
    step();
    @(negedge clk);
    chk("t6_c1_req", imem_req, 1'b1);
    chk("t6_c1_addr", imem_addr, 32'h0);
    chk("t6_c1_count", queue_count, 0);
    step();

    // Randomized traffic against the stream reference
    start_reset();
    hash_b = 1'b1;
    rst = 1'b0;
    pops_r = pops;
    for (int i = 0; i < 3000; i++) begin
      instr_ready  = ($urandom_range(0, 3) != 0);
      exe_redirect = ($urandom_range(0, 15) == 0);
      exe_pc       = 32'($urandom_range(0, 1023)) << 2;
      exe_imm      = 16'($urandom_range(0, 63) * 4) - 16'd128;
      step();
    end
    exe_redirect = 1'b0;
    chk("rand_liveness", (pops - pops_r) > 300, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
